// File: rtl/l_preamble_gen_pkg.sv
// Shared constants for the legacy preamble sequencer: state encoding,
// STF period and default section lengths / sample width.
package l_preamble_gen_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_STF  = 2'd1;
  localparam logic [1:0] S_LTF  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int L_STF_PERIOD = 16;
  localparam int STF_LEN_DEF  = 160;
  localparam int LTF_LEN_DEF  = 160;
  localparam int IQ_W_DEF     = 16;

endpackage

// File: rtl/l_preamble_gen_if.sv
// Valid/ready sample stream from the preamble sequencer to the sample mux.
interface l_preamble_gen_if
  import l_preamble_gen_pkg::*;
#(
  parameter int IQ_W = IQ_W_DEF
);

  logic [2*IQ_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              out_is_ltf;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    output out_is_ltf,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    input  out_is_ltf,
    output out_ready
  );

endinterface

// File: rtl/l_stf_rom.sv
// One 16-sample L-STF period, {I,Q} two's complement, Q1.15 scaling
// left-justified into IQ_W so it matches the L-LTF ROM.
module l_stf_rom
  import l_preamble_gen_pkg::*;
#(
  parameter int IQ_W = IQ_W_DEF
) (
  input  logic [3:0]        addr,
  output logic [2*IQ_W-1:0] data
);

  logic [15:0] i16;
  logic [15:0] q16;
  logic [IQ_W-1:0] iw;
  logic [IQ_W-1:0] qw;

  always_comb begin
    {i16, q16} = 32'h0;
    case (addr)
      4'd0:  {i16, q16} = 32'h05E3_05E3;
      4'd1:  {i16, q16} = 32'hEF1B_0042;
      4'd2:  {i16, q16} = 32'hFE56_F5E3;
      4'd3:  {i16, q16} = 32'h124E_FE56;
      4'd4:  {i16, q16} = 32'h0BC7_0000;
      4'd5:  {i16, q16} = 32'h124E_FE56;
      4'd6:  {i16, q16} = 32'hFE56_F5E3;
      4'd7:  {i16, q16} = 32'hEF1B_0042;
      4'd8:  {i16, q16} = 32'h05E3_05E3;
      4'd9:  {i16, q16} = 32'h0042_EF1B;
      4'd10: {i16, q16} = 32'hF5E3_FE56;
      4'd11: {i16, q16} = 32'hFE56_124E;
      4'd12: {i16, q16} = 32'h0000_0BC7;
      4'd13: {i16, q16} = 32'hFE56_124E;
      4'd14: {i16, q16} = 32'hF5E3_FE56;
      4'd15: {i16, q16} = 32'h0042_EF1B;
      default: {i16, q16} = 32'h0;
    endcase
  end

  // Left-justify so wider IQ_W keeps the same full-scale reference.
  assign iw   = IQ_W'(signed'(i16)) << (IQ_W - 16);
  assign qw   = IQ_W'(signed'(q16)) << (IQ_W - 16);
  assign data = {iw, qw};

endmodule

// File: rtl/l_preamble_gen.sv
// Streams 160 L-STF then 160 L-LTF samples through a single output register;
// first sample one cycle after start, one sample per cycle with ready high.
module l_preamble_gen
  import l_preamble_gen_pkg::*;
#(
  parameter int STF_LEN = STF_LEN_DEF,
  parameter int LTF_LEN = LTF_LEN_DEF,
  parameter int IQ_W    = IQ_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [7:0]        ltf_addr,
  input  logic [2*IQ_W-1:0] ltf_data,
  l_preamble_gen_if.master  out_if,
  output logic              busy,
  output logic              done
);

  logic [1:0]        state;
  logic [8:0]        idx;
  logic [2*IQ_W-1:0] stf_data;
  logic              xfer;
  logic              load;
  logic              stf_more;
  logic              ltf_more;

  l_stf_rom #(.IQ_W(IQ_W)) u_stf_rom (
    .addr (idx[3:0]),
    .data (stf_data)
  );

  assign xfer     = out_if.out_valid & out_if.out_ready;
  assign load     = ~out_if.out_valid | out_if.out_ready;
  assign stf_more = (idx != 9'(STF_LEN));
  assign ltf_more = (idx != 9'(LTF_LEN));
  // idx is the next sample to load; outside LTF the only LTF load is sample 0.
  assign ltf_addr = (state == S_LTF) ? idx[7:0] : 8'd0;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state             <= S_IDLE;
      idx               <= 9'd0;
      out_if.out_data   <= '0;
      out_if.out_valid  <= 1'b0;
      out_if.out_last   <= 1'b0;
      out_if.out_is_ltf <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state             <= S_STF;
            out_if.out_data   <= stf_data;
            out_if.out_valid  <= 1'b1;
            out_if.out_last   <= 1'b0;
            out_if.out_is_ltf <= 1'b0;
            idx               <= 9'd1;
          end
        end
        S_STF: begin
          if (load) begin
            if (stf_more) begin
              out_if.out_data  <= stf_data;
              out_if.out_valid <= 1'b1;
              idx              <= idx + 9'd1;
            end else if (xfer) begin
              // Final STF sample leaves as LTF sample 0 enters: no bubble.
              state             <= S_LTF;
              out_if.out_data   <= ltf_data;
              out_if.out_is_ltf <= 1'b1;
              out_if.out_last   <= (LTF_LEN == 1);
              idx               <= 9'd1;
            end
          end
        end
        S_LTF: begin
          if (load) begin
            if (ltf_more) begin
              out_if.out_data   <= ltf_data;
              out_if.out_valid  <= 1'b1;
              out_if.out_is_ltf <= 1'b1;
              out_if.out_last   <= (idx == 9'(LTF_LEN - 1));
              idx               <= idx + 9'd1;
            end else begin
              state             <= S_DONE;
              out_if.out_valid  <= 1'b0;
              out_if.out_last   <= 1'b0;
              out_if.out_is_ltf <= 1'b0;
              idx               <= 9'd0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l_preamble_gen.sv
// Scoreboard bench for l_preamble_gen with a behavioural L-LTF ROM.
module tb_l_preamble_gen;
  import l_preamble_gen_pkg::*;

  localparam int NS = 320;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  ltf_addr;
  logic [31:0] ltf_data;
  logic        busy;
  logic        done;

  l_preamble_gen_if #(.IQ_W(16)) oif ();

  l_preamble_gen dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .ltf_addr (ltf_addr),
    .ltf_data (ltf_data),
    .out_if   (oif.master),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [31:0] stf_tab [16] = '{
    32'h05E305E3, 32'hEF1B0042, 32'hFE56F5E3, 32'h124EFE56,
    32'h0BC70000, 32'h124EFE56, 32'hFE56F5E3, 32'hEF1B0042,
    32'h05E305E3, 32'h0042EF1B, 32'hF5E3FE56, 32'hFE56124E,
    32'h00000BC7, 32'hFE56124E, 32'hF5E3FE56, 32'h0042EF1B};

  function automatic logic [31:0] ltf_rom(input logic [7:0] a);
    case (a)
      8'd0:    return 32'hEC000000;
      8'd16:   return 32'h08000800;
      8'd159:  return 32'hFF580F67;
      default: return {a ^ 8'h5A, ~a, a, a ^ 8'hC3};
    endcase
  endfunction

  assign ltf_data = ltf_rom(ltf_addr);

  typedef struct {
    logic [31:0] d;
    logic        last;
    logic        ltf;
  } exp_t;

  exp_t sb_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int first_cyc, last_cyc, done_cyc;
  int rdy_mode = 0;
  int stall_at = -1;
  int stall_left = 0;
  logic [31:0] got [NS];
  logic        got_last [NS];
  logic        hold_pending = 1'b0;
  logic [34:0] hold_snap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Ready driver: fixed high, or random, with an optional forced stall.
  initial begin
    oif.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_at >= 0 && xfer_cnt == stall_at && stall_left > 0) begin
        oif.out_ready = 1'b0;
        stall_left--;
      end else begin
        oif.out_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Output monitor: pops the scoreboard on each transfer.
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending)
        chk("stall_hold", {oif.out_data, oif.out_valid, oif.out_last, oif.out_is_ltf}, hold_snap);
      hold_pending = oif.out_valid && !oif.out_ready;
      hold_snap    = {oif.out_data, oif.out_valid, oif.out_last, oif.out_is_ltf};
      if (oif.out_valid && oif.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("extra_sample", 64'(oif.out_data), 64'hDEAD);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("data", 64'(oif.out_data), 64'(e.d));
          chk("last", 64'(oif.out_last), 64'(e.last));
          chk("is_ltf", 64'(oif.out_is_ltf), 64'(e.ltf));
        end
        if (xfer_cnt < NS) begin
          got[xfer_cnt]      = oif.out_data;
          got_last[xfer_cnt] = oif.out_last;
        end
        if (xfer_cnt == 0) first_cyc = cyc;
        if (xfer_cnt == NS - 1) last_cyc = cyc;
        xfer_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_run;
    exp_t e;
    @(posedge clk);
    #1;
    start = 1'b1;
    xfer_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < NS; k++) begin
      e.d    = (k < 160) ? stf_tab[k % 16] : ltf_rom(8'(k - 160));
      e.last = (k == NS - 1);
      e.ltf  = (k >= 160);
      sb_q.push_back(e);
    end
    @(negedge clk);
    chk("lat_pre_valid", 64'(oif.out_valid), 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("lat_first", {oif.out_valid, oif.out_data}, {1'b1, stf_tab[0]});
    @(posedge clk);
    #1;
  endtask

  task automatic wait_xfer(input int n);
    int t;
    t = 0;
    while (xfer_cnt < n && t < 4000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (xfer_cnt < n) chk("wait_xfer_timeout", 64'(xfer_cnt), 64'(n));
  endtask

  task automatic wait_done(input int budget);
    int t;
    t = 0;
    while (done_cnt == 0 && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("done_seen", 64'(done_cnt != 0), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("reset_state", {oif.out_valid, oif.out_last, oif.out_is_ltf, busy, done, oif.out_data, ltf_addr}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle", {oif.out_valid, oif.out_last, oif.out_is_ltf, busy, done, oif.out_data, ltf_addr}, 0);
    end

    // Nominal run, ready held high.
    start_run();
    wait_done(1000);
    @(negedge clk);
    chk("busy_fall", {busy, done}, 0);
    chk("no_bubble", 64'(last_cyc - first_cyc), NS - 1);
    chk("done_lat", 64'(done_cyc - last_cyc), 1);
    chk("s0", 64'(got[0]), 64'(stf_tab[0]));
    chk("s16_eq_s0", 64'(got[16]), 64'(got[0]));
    chk("s159", 64'(got[159]), 64'(stf_tab[15]));
    chk("s160", 64'(got[160]), 64'h00000000EC000000);
    chk("s176", 64'(got[176]), 64'h0000000008000800);
    chk("s319", {got[319], got_last[319]}, {32'hFF580F67, 1'b1});
    chk("sb_empty_nom", 64'(sb_q.size()), 0);

    // Random backpressure plus a forced stall on the last STF sample.
    rdy_mode = 1;
    stall_at = 159;
    stall_left = 4;
    start_run();
    wait_done(4000);
    chk("stall_used", 64'(stall_left), 0);
    chk("sb_empty_bp", 64'(sb_q.size()), 0);
    rdy_mode = 0;
    stall_at = -1;
    repeat (3) @(posedge clk);
    #1;

    // Abort on the 200th transfer.
    start_run();
    wait_xfer(199);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("abort_out", {oif.out_valid, oif.out_last, busy, done}, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt), 0);
    start_run();
    wait_done(1000);
    chk("sb_empty_abort", 64'(sb_q.size()), 0);
    repeat (3) @(posedge clk);
    #1;

    // start pulses while busy are ignored.
    start_run();
    wait_xfer(5);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_xfer(170);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1000);
    repeat (6) @(posedge clk);
    #1;
    chk("one_done", 64'(done_cnt), 1);
    chk("sb_empty_busy", 64'(sb_q.size()), 0);
    chk("idle_after_busy", 64'(busy), 0);

    // Reset in the middle of STF.
    start_run();
    wait_xfer(80);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("rst_mid", {oif.out_valid, oif.out_last, oif.out_is_ltf, busy, done, oif.out_data, ltf_addr}, 0);
    start_run();
    wait_done(1000);
    chk("sb_empty_rst", 64'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
